// File: rtl/strip_frame_assembler.sv
// Assembles header-tagged strip link words into fixed-length frames and counts length errors.
// Optional frame watchdog: define FRAME_TIMEOUT_EN.
module strip_frame_assembler #(
    parameter int                PAYLOAD_W     = 26,
    parameter int                HDR_W         = 4,
    parameter logic [HDR_W-1:0]  HDR_PATTERN   = 4'b1010,
    parameter int                WORDS_PER_FRM = 4,
    parameter int                CNT_W         = 16,
    parameter int                ERR_W         = 8,
    parameter int                TIMEOUT_CYC   = 4096
) (
    input  logic                               clk160,
    input  logic                               reset_n,
    input  logic [HDR_W+PAYLOAD_W-1:0]         strip_data_in,
    input  logic                               linked,
    input  logic                               clear_err,
    output logic [WORDS_PER_FRM*PAYLOAD_W-1:0] frame_out,
    output logic                               frame_valid,
    output logic [CNT_W-1:0]                   frame_cnt,
    output logic [ERR_W-1:0]                   short_err_cnt,
    output logic [ERR_W-1:0]                   long_err_cnt,
    output logic [1:0]                         state,
    output logic                               timeout
);

    localparam int WORD_W  = HDR_W + PAYLOAD_W;
    localparam int FRAME_W = WORDS_PER_FRM * PAYLOAD_W;
    localparam int WIDX_W  = $clog2(WORDS_PER_FRM + 1);
    localparam logic [WIDX_W-1:0] WIDX_FULL = WIDX_W'(WORDS_PER_FRM);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OVERRUN = 2'd2
    } state_t;

    state_t              cur_state, nxt_state;
    logic [WIDX_W-1:0]   widx, nxt_widx;
    logic [FRAME_W-1:0]  shift_reg;
    logic                is_hdr;
    logic                shift_en, load_frame, inc_short, inc_long;

    assign is_hdr = (strip_data_in[WORD_W-1:PAYLOAD_W] == HDR_PATTERN);
    assign state  = cur_state;

    always_ff @(posedge clk160 or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= IDLE;
            widx      <= '0;
        end else begin
            cur_state <= nxt_state;
            widx      <= nxt_widx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        nxt_state  = cur_state;
        nxt_widx   = widx;
        shift_en   = 1'b0;
        load_frame = 1'b0;
        inc_short  = 1'b0;
        inc_long   = 1'b0;
        if (!linked) begin
            // Partial run is dropped silently while the link is down.
            nxt_state = IDLE;
            nxt_widx  = '0;
        end else begin
            unique case (cur_state)
                IDLE: begin
                    if (is_hdr) begin
                        nxt_state = COLLECT;
                        nxt_widx  = WIDX_W'(1);
                        shift_en  = 1'b1;
                    end
                end
                COLLECT: begin
                    if (is_hdr) begin
                        if (widx < WIDX_FULL) begin
                            nxt_widx = widx + WIDX_W'(1);
                            shift_en = 1'b1;
                        end else begin
                            nxt_state = OVERRUN;
                            nxt_widx  = '0;
                            inc_long  = 1'b1;
                        end
                    end else begin
                        nxt_state = IDLE;
                        nxt_widx  = '0;
                        if (widx == WIDX_FULL) load_frame = 1'b1;
                        else                   inc_short  = 1'b1;
                    end
                end
                OVERRUN: begin
                    if (!is_hdr) nxt_state = IDLE;
                end
                default: begin
                    nxt_state = IDLE;
                    nxt_widx  = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk160 or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg     <= '0;
            frame_out     <= '0;
            frame_valid   <= 1'b0;
            frame_cnt     <= '0;
            short_err_cnt <= '0;
            long_err_cnt  <= '0;
        end else begin
            if (shift_en)
                shift_reg <= {shift_reg[FRAME_W-PAYLOAD_W-1:0], strip_data_in[PAYLOAD_W-1:0]};
            frame_valid <= load_frame;
            if (load_frame) frame_out <= shift_reg;
            if (clear_err) begin
                frame_cnt     <= '0;
                short_err_cnt <= '0;
                long_err_cnt  <= '0;
            end else begin
                if (load_frame) frame_cnt <= frame_cnt + CNT_W'(1);
                if (inc_short && short_err_cnt != '1) short_err_cnt <= short_err_cnt + ERR_W'(1);
                if (inc_long && long_err_cnt != '1)   long_err_cnt  <= long_err_cnt + ERR_W'(1);
            end
        end
    end

`ifdef FRAME_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0] wd_cnt;

    // Watchdog saturates at its last count; timeout rises as that count is reached.
    always_ff @(posedge clk160 or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (!linked || frame_valid)  wd_cnt <= '0;
            else if (wd_cnt != WD_LAST)  wd_cnt <= wd_cnt + WD_W'(1);
            if (clear_err)
                timeout <= 1'b0;
            else if (linked && !frame_valid && wd_cnt == WD_LAST - WD_W'(1))
                timeout <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_strip_frame_assembler.sv
// Directed bench for strip_frame_assembler with hand-computed expectations.
// With FRAME_TIMEOUT_EN defined, the DUT is built with TIMEOUT_CYC=64 and the watchdog is exercised.
module tb_strip_frame_assembler;

    localparam int PW = 26;
    localparam int FW = 4 * PW;

    logic          clk160 = 1'b0;
    logic          reset_n;
    logic [29:0]   strip_data_in;
    logic          linked;
    logic          clear_err;
    logic [FW-1:0] frame_out;
    logic          frame_valid;
    logic [15:0]   frame_cnt;
    logic [7:0]    short_err_cnt;
    logic [7:0]    long_err_cnt;
    logic [1:0]    state;
    logic          timeout;

    int n_vec = 0;
    int n_err = 0;

    strip_frame_assembler #(
`ifdef FRAME_TIMEOUT_EN
        .TIMEOUT_CYC(64)
`else
        .TIMEOUT_CYC(4096)
`endif
    ) dut (
        .clk160       (clk160),
        .reset_n      (reset_n),
        .strip_data_in(strip_data_in),
        .linked       (linked),
        .clear_err    (clear_err),
        .frame_out    (frame_out),
        .frame_valid  (frame_valid),
        .frame_cnt    (frame_cnt),
        .short_err_cnt(short_err_cnt),
        .long_err_cnt (long_err_cnt),
        .state        (state),
        .timeout      (timeout)
    );

    always #5 clk160 = ~clk160;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one word, let the DUT sample it, and return 1 time unit after the edge.
    task automatic send(input logic [29:0] w);
        strip_data_in = w;
        @(posedge clk160);
        #1;
    endtask

    task automatic send_hdr(input logic [PW-1:0] p);
        send({4'hA, p});
    endtask

    task automatic send_gap();
        send(30'h0);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    logic [PW-1:0] pa [4];
    logic [PW-1:0] pb [4];
    logic [FW-1:0] exp_a, exp_b;

    initial begin
        pa = '{26'h1234567, 26'h0ABCDEF, 26'h3FFFFFF, 26'h0000001};
        pb = '{26'h2AAAAAA, 26'h1555555, 26'h0F0F0F0, 26'h3000003};
        exp_a = {pa[0], pa[1], pa[2], pa[3]};
        exp_b = {pb[0], pb[1], pb[2], pb[3]};

        reset_n       = 1'b0;
        strip_data_in = '0;
        linked        = 1'b1;
        clear_err     = 1'b0;
        #3;
        check("reset_frame_out", frame_out, 0);
        check("reset_valid", frame_valid, 0);
        check("reset_cnt", frame_cnt, 0);
        check("reset_state", state, 0);
        check("reset_timeout", timeout, 0);
        #9;
        reset_n = 1'b1;

        // 1: one good frame
        send_hdr(pa[0]);
        check("t1_state_collect", state, 1);
        for (int i = 1; i < 4; i++) send_hdr(pa[i]);
        check("t1_valid_before_gap", frame_valid, 0);
        send_gap();
        check("t1_valid", frame_valid, 1);
        check("t1_frame", frame_out, exp_a);
        check("t1_cnt", frame_cnt, 1);
        check("t1_short", short_err_cnt, 0);
        check("t1_long", long_err_cnt, 0);
        check("t1_state_idle", state, 0);
        send_gap();
        check("t1_valid_one_cycle", frame_valid, 0);

        // 2: short run
        for (int i = 0; i < 3; i++) send_hdr(pb[i]);
        send_gap();
        check("t2_valid", frame_valid, 0);
        check("t2_short", short_err_cnt, 1);
        check("t2_frame_held", frame_out, exp_a);

        // 3: long run
        for (int i = 0; i < 5; i++) send_hdr(pb[i % 4]);
        check("t3_state_overrun", state, 2);
        check("t3_long_early", long_err_cnt, 1);
        send_hdr(pb[1]);
        send_hdr(pb[2]);
        check("t3_still_overrun", state, 2);
        send_gap();
        check("t3_state_idle", state, 0);
        check("t3_long", long_err_cnt, 1);
        check("t3_valid", frame_valid, 0);
        check("t3_cnt", frame_cnt, 1);

        // 4: back-to-back runs, strobes 5 cycles apart
        for (int i = 0; i < 4; i++) send_hdr(pb[i]);
        send_gap();
        check("t4_valid_a", frame_valid, 1);
        check("t4_frame_a", frame_out, exp_b);
        for (int i = 0; i < 4; i++) begin
            send_hdr(pa[i]);
            check("t4_no_valid_between", frame_valid, 0);
        end
        send_gap();
        check("t4_valid_b", frame_valid, 1);
        check("t4_frame_b", frame_out, exp_a);
        check("t4_cnt", frame_cnt, 3);

        // 5: linked drops mid-run, then reset mid-run
        send_hdr(pa[0]);
        send_hdr(pa[1]);
        linked = 1'b0;
        send_hdr(pa[2]);
        check("t5_unlinked_idle", state, 0);
        linked = 1'b1;
        send_gap();
        check("t5_no_short", short_err_cnt, 1);
        check("t5_no_long", long_err_cnt, 1);
        send_hdr(pa[0]);
        send_hdr(pa[1]);
        reset_n = 1'b0;
        #2;
        check("t5_rst_state", state, 0);
        check("t5_rst_frame", frame_out, 0);
        check("t5_rst_cnt", frame_cnt, 0);
        check("t5_rst_short", short_err_cnt, 0);
        check("t5_rst_long", long_err_cnt, 0);
        check("t5_rst_valid", frame_valid, 0);
        reset_n = 1'b1;

        // 6: saturation, then clear_err coincident with a good frame
        for (int i = 0; i < 300; i++) begin
            send_hdr(26'h0000055);
            send_gap();
        end
        check("t6_short_sat", short_err_cnt, 255);
        for (int i = 0; i < 4; i++) send_hdr(pa[i]);
        send_gap();
        check("t6_cnt_before_clear", frame_cnt, 1);
        for (int i = 0; i < 5; i++) send_hdr(pb[0]);
        send_gap();
        check("t6_long_before_clear", long_err_cnt, 1);
        for (int i = 0; i < 4; i++) send_hdr(pb[i]);
        clear_err = 1'b1;
        send_gap();
        clear_err = 1'b0;
        check("t6_clear_valid", frame_valid, 1);
        check("t6_clear_frame", frame_out, exp_b);
        check("t6_clear_cnt", frame_cnt, 0);
        check("t6_clear_short", short_err_cnt, 0);
        check("t6_clear_long", long_err_cnt, 0);

`ifdef FRAME_TIMEOUT_EN
        pulse_reset();
        for (int i = 0; i < 62; i++) send_gap();
        check("t7_timeout_early", timeout, 0);
        send_gap();
        check("t7_timeout_63", timeout, 1);
        clear_err = 1'b1;
        send_gap();
        clear_err = 1'b0;
        check("t7_timeout_clear", timeout, 0);
`else
        pulse_reset();
        for (int i = 0; i < 70; i++) send_gap();
        check("t7_timeout_tied", timeout, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
